// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the runtime-configurable serial pattern detector.
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } seq_state_e;

    // Width needed to hold a pattern length in the range 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module seq_det_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/param_seq_detector.sv
// Mealy serial-pattern detector with runtime-loadable pattern, length and overlap mode.
// Optional match counter built only when SEQ_DET_MATCH_COUNT_EN is defined.
//
//   state | meaning
//   ------+------------------------------------------------
//   IDLE  | no legal configuration loaded; never detects
//   ARMED | shadow config valid; searching the bit stream
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = len_w(MAX_LEN),
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap_en,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               detected,
    output logic               armed,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

    seq_state_e         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-2:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic               cfg_err_q;

    logic               cfg_ok;
    logic               cfg_accept;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic               fill_ok;
    logic               pat_hit;

    assign cfg_ok     = (pat_len != '0) && (int'(pat_len) <= MAX_LEN);
    assign cfg_accept = cfg_load && cfg_ok;
    assign cand       = {hist_q, in_bit};
    assign fill_ok    = (int'(fill_q) + 1) >= int'(len_q);
    assign pat_hit    = (((cand ^ pat_q) & mask) == '0);
    assign armed      = (state_q == ARMED);
    assign cfg_err    = cfg_err_q;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        detected = 1'b0;
        if (cfg_accept) begin
            state_d = ARMED;
        end
        // A load in the same cycle discards the incoming bit entirely.
        if ((state_q == ARMED) && in_valid && !cfg_load && fill_ok && pat_hit) begin
            detected = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_load && !cfg_ok;
            if (cfg_load) begin
                if (cfg_ok) begin
                    pat_q  <= pattern;
                    len_q  <= pat_len;
                    ovl_q  <= overlap_en;
                    hist_q <= '0;
                    fill_q <= '0;
                end
            end else if (in_valid) begin
                if (detected && !ovl_q) begin
                    hist_q <= '0;
                    fill_q <= '0;
                end else begin
                    hist_q <= cand[MAX_LEN-2:0];
                    if (fill_q != FILL_MAX) begin
                        fill_q <= fill_q + 1'b1;
                    end
                end
            end
        end
    end

`ifdef SEQ_DET_MATCH_COUNT_EN
    seq_det_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cfg_accept),
        .inc     (detected),
        .count   (match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Parametrised Mealy serial-pattern detector; successor to the fixed "101" detector.
- Pattern, length (1..MAX_LEN) and overlap mode are runtime-loadable; the input is qualified by a valid strobe.
- Provides a saturating match counter.
- Sits on a serial bit stream, e.g. a frame-sync or marker search in front of a deserialiser.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of pat_len.
- CNT_W, 8, width of match_count.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- cfg_load  in  1  one-cycle strobe; latch pattern/pat_len/overlap_en
- pattern  in  MAX_LEN  pattern bits; bit pat_len-1 is the first bit received, bit 0 is the last
- pat_len  in  LEN_W  pattern length; legal 1..MAX_LEN
- overlap_en  in  1  1 = overlapping matches allowed
- in_valid  in  1  in_bit is valid this cycle
- in_bit  in  1  serial data bit
- detected  out  1  Mealy output: combinational, high in the cycle the final matching bit is presented
- armed  out  1  a legal configuration is loaded
- cfg_err  out  1  registered one-cycle pulse; cfg_load was rejected
- match_count  out  CNT_W  number of matches since the last reset or accepted load; saturating

Behaviour:
- Reset (async assert, sync release) values:
  - FSM = IDLE; history = 0; fill = 0; shadow config = 0.
  - detected = 0, armed = 0, cfg_err = 0, match_count = 0.
- FSM states: IDLE (no legal configuration) and ARMED.
  - IDLE -> ARMED on a legal cfg_load.
  - ARMED -> ARMED on a legal cfg_load: reconfigure.
  - Any state, illegal cfg_load (pat_len = 0 or > MAX_LEN): cfg_err pulses the next cycle; state and shadow config are unchanged.
- Accepted cfg_load:
  - Latches pattern, pat_len and overlap_en into shadow registers.
  - Clears history, fill and match_count. The next in_valid bit is bit 1 of a new search.
- Datapath:
  - history is a MAX_LEN-1 bit shift register of past valid bits, newest at bit 0.
  - fill is a counter of valid bits held, saturating at MAX_LEN-1.
  - cand = {history, in_bit}, using its low pat_len bits.
- detected = armed & in_valid & !cfg_load & (fill >= pat_len-1) & (cand[pat_len-1:0] == pattern[pat_len-1:0]).
  - Zero latency from in_bit; no registered delay.
- On each in_valid cycle without cfg_load:
  - history shifts in in_bit and fill increments (saturating).
  - If detected is high and overlap_en = 0, history and fill clear instead. The matched bits cannot be reused.
  - If overlap_en = 1, the shift proceeds normally.
- in_valid = 0: history, fill and outputs hold; detected = 0.
- pat_len = 1: every valid bit equal to pattern[0] is detected, in both modes.
- Simultaneous cfg_load and in_valid: cfg_load wins, in_bit is discarded, detected = 0.
- IDLE: bits are shifted but detected is never asserted.
- match_count increments on each detected cycle and saturates at 2^CNT_W-1; it never wraps.
- Reset mid-stream: all state is lost immediately; armed = 0 until the next legal load.

Optional Feature:
- Macro: SEQ_DET_MATCH_COUNT_EN.
- Defined: match_count counter is implemented as described.
- Undefined: counter logic is omitted; match_count is tied to 0; the port remains present.
- detected, armed and cfg_err are identical in both builds.

Decomposition:
- Shared package seq_det_pkg:
  - state enum (IDLE, ARMED);
  - LEN_W computation function;
  - default MAX_LEN and CNT_W constants.
- One natural sub-module: seq_det_sat_counter, a CNT_W saturating counter with clear and increment.
  - Instantiated under SEQ_DET_MATCH_COUNT_EN.

Test Plan:
- Load pattern=3'b101, pat_len=3, overlap_en=1; drive 1,0,1,0,1 -> detected high on bits 3 and 5; match_count=2.
- Same stream with overlap_en=0 -> detected high on bit 3 only; match_count=1.
- Load pattern=4'b1101, pat_len=4; drive 1,1,0,1 with in_valid gaps between bits -> single detection on the 4th valid bit; no detection during gaps.
- cfg_load with pat_len=0 while armed -> cfg_err pulse, armed stays 1, old pattern still detected; pat_len=9 with MAX_LEN=8 -> same result.
- cfg_load and in_valid in the same cycle as a completing bit -> detected=0, match_count=0, next search starts fresh.
- CNT_W=2, pattern=1'b1, pat_len=1; drive 5 ones -> count reads 3 and holds; reset_n low mid-stream -> all outputs 0 asynchronously. Repeat without the macro -> match_count stays 0.
